// File: rtl/multdiv_pkg.sv
// Shared constants for the iterative signed multiply/divide unit.
package multdiv_pkg;

  localparam int W      = 32;
  localparam int N_ITER = 32;
  localparam int CNT_W  = 6;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: signed shift-add for multiply,
// restoring compare/subtract for divide. Purely combinational.
module multdiv_step
  import multdiv_pkg::*;
(
  input  op_e          op,
  input  logic         last,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] lo,
  input  logic [W-1:0] opnd,
  output logic [W-1:0] hi_n,
  output logic [W-1:0] lo_n
);

  logic [W:0]   addend;
  logic [W:0]   sum;
  logic [W-1:0] rem_sh;
  logic [W:0]   diff;

  always_comb begin
    addend = '0;
    sum    = '0;
    rem_sh = '0;
    diff   = '0;
    hi_n   = hi;
    lo_n   = lo;
    if (op == OP_MULT) begin
      // Multiplier sign bit carries weight -2^31, so the last step subtracts.
      if (lo[0]) begin
        addend = last ? -{opnd[W-1], opnd} : {opnd[W-1], opnd};
      end
      sum  = {hi[W-1], hi} + addend;
      hi_n = sum[W:1];
      lo_n = {sum[0], lo[W-1:1]};
    end else begin
      rem_sh = {hi[W-2:0], lo[W-1]};
      diff   = {1'b0, rem_sh} - {1'b0, opnd};
      if (!diff[W]) begin
        hi_n = diff[W-1:0];
        lo_n = {lo[W-2:0], 1'b1};
      end else begin
        hi_n = rem_sh;
        lo_n = {lo[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/multdiv.sv
// Iterative 32-bit signed multiply / divide, 32 steps per operation.
// Optional MULTDIV_OVF_EN flags signed overflow of the multiply low word.
//
// state | meaning
// IDLE  | waiting for a start pulse
// RUN   | one datapath step per cycle, 32 cycles
// DONE  | result registered, completion strobe high
module multdiv
  import multdiv_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] data_operandA,
  input  logic [W-1:0] data_operandB,
  input  logic         ctrl_MULT,
  input  logic         ctrl_DIV,
  output logic [W-1:0] data_result,
  output logic         data_exception,
  output logic         data_resultRDY
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic [W-1:0]     result_q, result_d;
  logic             exc_q, exc_d;

  logic             start;
  logic             step_en;
  logic             last_iter;
  logic [W-1:0]     step_hi, step_lo;
  logic [W-1:0]     fin_res;
  logic             fin_exc;

  assign start = ctrl_MULT | ctrl_DIV;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (start)                  state_d = ST_RUN;
        else if (cnt_q == LAST_CNT) state_d = ST_DONE;
      end
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_resultRDY = (state_q == ST_DONE);
    step_en        = (state_q == ST_RUN) && !start;
    last_iter      = (cnt_q == LAST_CNT);
  end

  multdiv_step u_step (
    .op   (op_q),
    .last (last_iter),
    .hi   (hi_q),
    .lo   (lo_q),
    .opnd (opnd_q),
    .hi_n (step_hi),
    .lo_n (step_lo)
  );

`ifdef MULTDIV_OVF_EN
  logic [W:0] prod_top;
  assign prod_top = {step_hi, step_lo[W-1]};
`endif

  always_comb begin
    fin_res = '0;
    fin_exc = 1'b0;
    if (op_q == OP_MULT) begin
      fin_res = step_lo;
`ifdef MULTDIV_OVF_EN
      fin_exc = !((&prod_top) || !(|prod_top));
`endif
    end else if (dz_q) begin
      fin_exc = 1'b1;
    end else begin
      fin_res = neg_q ? -step_lo : step_lo;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (start) begin
      op_d   = ctrl_MULT ? OP_MULT : OP_DIV;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = ctrl_MULT ? data_operandB : mag(data_operandA);
      opnd_d = ctrl_MULT ? data_operandA : mag(data_operandB);
      neg_d  = data_operandA[W-1] ^ data_operandB[W-1];
      dz_d   = (data_operandB == '0);
    end else if (step_en) begin
      cnt_d = cnt_q + 1'b1;
      hi_d  = step_hi;
      lo_d  = step_lo;
      if (last_iter) begin
        result_d = fin_res;
        exc_d    = fin_exc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= OP_MULT;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;

endmodule

// File: tb/tb_multdiv.sv
// Directed-vector bench for multdiv; expected values are hand-computed.
`timescale 1ns/1ps
module tb_multdiv;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MULTDIV_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  multdiv dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Caller sits at a negedge; returns at the negedge just before start edge + 1.
  task automatic start_op(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = ctl[1];
    ctrl_DIV      = ctl[0];
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = ~a;
    data_operandB = b ^ 32'h5A5A_0001;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 1;
    while (!data_resultRDY && lat < 60) begin
      @(negedge clock);
      lat++;
    end
    if (!data_resultRDY) lat = -1;
  endtask

  task automatic run_op(input string tag, input logic [1:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_exc);
    int lat;
    start_op(ctl, a, b);
    wait_rdy(lat);
    check_val({tag, "_lat"}, 32'(lat), 32'd33);
    check_val({tag, "_res"}, data_result, exp_res);
    check_val({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
    @(negedge clock);
    check_val({tag, "_rdy_1cyc"}, {31'd0, data_resultRDY}, 32'd0);
    repeat (4) @(negedge clock);
    check_val({tag, "_hold"}, data_result, exp_res);
  endtask

  initial begin
    int seen;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check_val("rst_res", data_result, 32'd0);
    check_val("rst_exc", {31'd0, data_exception}, 32'd0);
    check_val("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run_op("mul_7_m3",    2'b10, 32'd7,          -32'sd3,       32'hFFFF_FFEB, 1'b0);
    run_op("div_m17_5",   2'b01, -32'sd17,       32'd5,         32'hFFFF_FFFD, 1'b0);
    run_op("div_5_0",     2'b01, 32'd5,          32'd0,         32'h0000_0000, 1'b1);
    run_op("mul_ovf",     2'b10, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, OVF_EXP);
    run_op("div_min_m1",  2'b01, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("mul_100_m100",2'b10, 32'd100,        -32'sd100,     32'hFFFF_D8F0, 1'b0);
    run_op("mul_m7_m3",   2'b10, -32'sd7,        -32'sd3,       32'd21,        1'b0);
    run_op("div_100_m7",  2'b01, 32'd100,        -32'sd7,       32'hFFFF_FFF2, 1'b0);

    // Divide started, then aborted by a multiply at cycle 10: single strobe at 43.
    seen = 0;
    start_op(2'b01, 32'd100, 32'd7);
    repeat (9) begin
      if (data_resultRDY) seen++;
      @(negedge clock);
    end
    run_op("abort_mul_3_4", 2'b10, 32'd3, 32'd4, 32'd12, 1'b0);
    check_val("abort_no_early_rdy", 32'(seen), 32'd0);

    // Reset at cycle 20 of a multiply: outputs cleared, no strobe follows.
    seen = 0;
    start_op(2'b10, 32'd9, 32'd9);
    repeat (19) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("midrst_res", data_result, 32'd0);
    check_val("midrst_exc", {31'd0, data_exception}, 32'd0);
    repeat (50) begin
      if (data_resultRDY) seen++;
      @(negedge clock);
    end
    check_val("midrst_no_rdy", 32'(seen), 32'd0);

    // Both start pulses together: multiply wins.
    run_op("both_6_2", 2'b11, 32'd6, 32'd2, 32'd12, 1'b0);

    // Reset overrides a simultaneous start.
    seen = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    @(negedge clock);
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    repeat (40) begin
      if (data_resultRDY) seen++;
      @(negedge clock);
    end
    check_val("rst_vs_start_no_rdy", 32'(seen), 32'd0);
    check_val("rst_vs_start_res", data_result, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multdiv.md
MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 SHALL have port clock, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port data_operandA, input, 32, signed multiplicand or dividend.
REQ-004 SHALL have port data_operandB, input, 32, signed multiplier or divisor.
REQ-005 SHALL have port ctrl_MULT, input, 1, single-cycle start-multiply pulse.
REQ-006 SHALL have port ctrl_DIV, input, 1, single-cycle start-divide pulse.
REQ-007 SHALL have port data_result, output, 32, product low word or quotient.
REQ-008 SHALL have port data_exception, output, 1, error flag, valid with data_resultRDY.
REQ-009 SHALL have port data_resultRDY, output, 1, one-cycle completion strobe.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE, with a 6-bit iteration counter.
REQ-011 SHALL, on any edge where ctrl_MULT or ctrl_DIV is sampled high, latch both operands and the operation, clear the counter and enter RUN.
REQ-012 SHALL give ctrl_MULT priority when both start pulses are high in the same cycle; the operation runs as a multiply.
REQ-013 SHALL, when a start pulse arrives in RUN or DONE, abort the current operation and restart with the new operands; no strobe is issued for the aborted operation.
REQ-014 SHALL perform one iteration per cycle in RUN, 32 iterations total, then enter DONE.
REQ-015 SHALL assert data_resultRDY for exactly the one cycle in DONE, which is the 33rd edge after the start edge, then return to IDLE.
REQ-016 SHALL multiply as radix-2 signed shift-add and output the low 32 bits of the 64-bit product.
REQ-017 SHALL divide by restoring division on magnitudes, truncate toward zero, make the quotient negative iff operand signs differ, and discard the remainder.
REQ-018 SHALL, on divide by zero, produce data_result=0 and data_exception=1 with the same 33-cycle latency.
REQ-019 SHALL produce the quotient 0x80000000 with data_exception=0 for 0x80000000 / -1, since the result wraps.
REQ-020 SHALL hold data_result and data_exception stable from DONE until the next start edge.
REQ-021 SHALL ignore operand input changes after the latch edge.

Reset
REQ-022 SHALL, when reset is sampled high, force state IDLE, counter 0, data_result=0, data_exception=0 and data_resultRDY=0 on that edge.
REQ-023 SHALL let reset override a simultaneous start pulse.
REQ-024 SHALL, if reset occurs mid-RUN, drop the operation with no strobe.

Configuration
REQ-025 SHALL, with macro MULTDIV_OVF_EN defined, set data_exception on a multiply whenever the 64-bit product's upper 33 bits are not all equal (signed overflow).
REQ-026 SHALL, without MULTDIV_OVF_EN, hold data_exception at 0 for all multiplies; divide-by-zero reporting is unaffected.

Structure
REQ-027 SHALL place the state encodings, the 32-bit width and the iteration count (32) in a shared constants package.
REQ-028 SHALL place one iteration of datapath in a combinational sub-module, multdiv_step, covering conditional add/subtract and 1-bit shift for both modes.
REQ-029 SHALL keep the FSM, counter and operand/accumulator registers in multdiv.

Verification
REQ-030 SHALL cover: ctrl_MULT, A=7, B=-3 -> resultRDY exactly 33 cycles later, result=0xFFFFFFEB, exception=0.
REQ-031 SHALL cover: ctrl_DIV, A=-17, B=5 -> result=0xFFFFFFFD (-3), exception=0; and A=5, B=0 -> result=0, exception=1.
REQ-032 SHALL cover: ctrl_MULT, A=0x00010000, B=0x00010000 -> result=0 and exception=1 with MULTDIV_OVF_EN, exception=0 without it.
REQ-033 SHALL cover: ctrl_DIV at cycle 0, then ctrl_MULT with A=3, B=4 at cycle 10 -> a single strobe at cycle 43, result=12.
REQ-034 SHALL cover: reset at cycle 20 of a multiply -> no strobe, outputs 0; ctrl_MULT and ctrl_DIV together with A=6, B=2 -> result=12.
